cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the team's 4-bit lookahead adder.
- Scales to the datapath width.
- Adds a subtract mode, ALU flags and a valid/ready handshake.
- Sits between the register-read stage and the ALU result mux; also usable standalone for address arithmetic.

---
 rtl/cla_pkg.sv | 21 ++
 rtl/cla_group.sv | 55 +++++
 rtl/cla_pipe_adder.sv | 210 +++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, flag bundle and group-count helper for the
// pipelined carry-lookahead adder.
package cla_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_GROUP = 4;
    localparam int LATENCY   = 3;

    // ALU flags produced alongside the sum
    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } cla_flags_t;

    // Number of lookahead groups; WIDTH is expected to be a multiple of GROUP
    function automatic int calc_ngrp(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: GROUP-bit combinational lookahead cell. Produces the group
// propagate/generate and the carry into every bit of the group, all in
// flattened sum-of-products form (no ripple between bits).
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_p,
    input  logic [GROUP-1:0] i_g,
    input  logic             i_cin,
    output logic             o_grp_p,
    output logic             o_grp_g,
    output logic [GROUP-1:0] o_carry
);

    // Group propagate: every bit propagates
    assign o_grp_p = &i_p;

    // Group generate and per-bit carries as lookahead OR-of-ANDs
    always_comb begin
        logic w_term;
        logic w_acc;
        o_carry = '0;
        o_grp_g = 1'b0;
        w_term  = 1'b0;
        w_acc   = 1'b0;
        // carry into bit i: cin propagated through bits 0..i-1, or a generate
        // at bit j < i propagated through bits j+1..i-1
        for (int i = 0; i < GROUP; i++) begin
            w_term = i_cin;
            for (int m = 0; m < i; m++) begin
                w_term = w_term & i_p[m];
            end
            w_acc = w_term;
            for (int j = 0; j < i; j++) begin
                w_term = i_g[j];
                for (int m = j + 1; m < i; m++) begin
                    w_term = w_term & i_p[m];
                end
                w_acc = w_acc | w_term;
            end
            o_carry[i] = w_acc;
        end
        // generate out of the group, independent of cin
        w_acc = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            w_term = i_g[j];
            for (int m = j + 1; m < GROUP; m++) begin
                w_term = w_term & i_p[m];
            end
            w_acc = w_acc | w_term;
        end
        o_grp_g = w_acc;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: 3-stage pipelined carry-lookahead adder/subtractor with a
// valid/ready handshake and cout/ovf/zero flags.
//   S1: operands, inverted b for subtract, carry-in
//   S2: per-bit p/g, per-group P/G
//   S3: group carries, bit carries, sum and flags
// Optional build macro CLA_PG_OUT_EN adds gp/gg outputs carrying the group
// propagate/generate of the result currently held in S3.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int GROUP = DEF_GROUP,
    localparam int NGRP  = calc_ngrp(WIDTH, GROUP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
`ifdef CLA_PG_OUT_EN
    ,
    output logic [NGRP-1:0]  gp,
    output logic [NGRP-1:0]  gg
`endif
);

    logic             w_stall;
    logic             w_advance;
    logic             r_v1;
    logic             r_v2;
    logic             r_v3;

    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic [WIDTH-1:0] w_s1_p;
    logic [WIDTH-1:0] w_s1_g;
    logic [NGRP-1:0]  w_s1_gp;
    logic [NGRP-1:0]  w_s1_gg;
    logic [WIDTH-1:0] w_unused_s1_carry;

    logic [WIDTH-1:0] r_s2_p;
    logic [WIDTH-1:0] r_s2_g;
    logic [NGRP-1:0]  r_s2_gp;
    logic [NGRP-1:0]  r_s2_gg;
    logic             r_s2_cin;

    logic [NGRP:0]    w_s3_cgrp;
    logic [WIDTH-1:0] w_s3_carry;
    logic [WIDTH-1:0] w_s3_sum;
    logic [NGRP-1:0]  w_unused_s3_gp;
    logic [NGRP-1:0]  w_unused_s3_gg;
    cla_flags_t       w_s3_flags;

    logic [WIDTH-1:0] r_s3_sum;
    cla_flags_t       r_s3_flags;

    // A presented result that is not taken freezes the whole pipeline.
    // Reset forces in_ready high so the block looks idle while it clears.
    assign w_stall   = r_v3 & ~out_ready;
    assign w_advance = ~w_stall;
    assign in_ready  = ~w_stall | reset;
    assign out_valid = r_v3;

    // Valid bits travel with the data; bubbles are kept, reset overrides stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_advance) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    // S1 capture: subtract is a + ~b + 1, so c0 is ignored in that mode
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1_a   <= a;
            r_s1_b   <= sub ? ~b : b;
            r_s1_cin <= sub | c0;
        end
    end

    assign w_s1_p = r_s1_a ^ r_s1_b;
    assign w_s1_g = r_s1_a & r_s1_b;

    // Group P/G cells feeding S2; bit carries are resolved later in S3
    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_s2_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .i_p     (w_s1_p[gi*GROUP +: GROUP]),
                .i_g     (w_s1_g[gi*GROUP +: GROUP]),
                .i_cin   (1'b0),
                .o_grp_p (w_s1_gp[gi]),
                .o_grp_g (w_s1_gg[gi]),
                .o_carry (w_unused_s1_carry[gi*GROUP +: GROUP])
            );
        end
    endgenerate

    // S2 capture: per-bit p/g, per-group P/G and the effective carry-in
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s2_p   <= w_s1_p;
            r_s2_g   <= w_s1_g;
            r_s2_gp  <= w_s1_gp;
            r_s2_gg  <= w_s1_gg;
            r_s2_cin <= r_s1_cin;
        end
    end

    // Group carries in flattened lookahead form: Cgrp[k+1] is the OR of every
    // group generate j <= k propagated through groups j+1..k, plus cin
    // propagated through groups 0..k
    always_comb begin
        logic w_term;
        logic w_acc;
        w_s3_cgrp    = '0;
        w_term       = 1'b0;
        w_acc        = 1'b0;
        w_s3_cgrp[0] = r_s2_cin;
        for (int k = 0; k < NGRP; k++) begin
            w_term = r_s2_cin;
            for (int m = 0; m <= k; m++) begin
                w_term = w_term & r_s2_gp[m];
            end
            w_acc = w_term;
            for (int j = 0; j <= k; j++) begin
                w_term = r_s2_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    w_term = w_term & r_s2_gp[m];
                end
                w_acc = w_acc | w_term;
            end
            w_s3_cgrp[k+1] = w_acc;
        end
    end

    // In-group bit carries driven by each group's incoming carry
    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_s3_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .i_p     (r_s2_p[gi*GROUP +: GROUP]),
                .i_g     (r_s2_g[gi*GROUP +: GROUP]),
                .i_cin   (w_s3_cgrp[gi]),
                .o_grp_p (w_unused_s3_gp[gi]),
                .o_grp_g (w_unused_s3_gg[gi]),
                .o_carry (w_s3_carry[gi*GROUP +: GROUP])
            );
        end
    endgenerate

    assign w_s3_sum = r_s2_p ^ w_s3_carry;

    // Flags: signed overflow when carry into the MSB differs from carry out
    always_comb begin
        w_s3_flags      = '0;
        w_s3_flags.cout = w_s3_cgrp[NGRP];
        w_s3_flags.ovf  = w_s3_carry[WIDTH-1] ^ w_s3_cgrp[NGRP];
        w_s3_flags.zero = (w_s3_sum == '0);
    end

    // S3 output registers; reset clears them without recomputing zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3_sum   <= '0;
            r_s3_flags <= '0;
        end else if (w_advance) begin
            r_s3_sum   <= w_s3_sum;
            r_s3_flags <= w_s3_flags;
        end
    end

`ifdef CLA_PG_OUT_EN
    logic [NGRP-1:0] r_s3_gp;
    logic [NGRP-1:0] r_s3_gg;

    // Group P/G of the transaction in S3, kept in step with the sum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3_gp <= '0;
            r_s3_gg <= '0;
        end else if (w_advance) begin
            r_s3_gp <= r_s2_gp;
            r_s3_gg <= r_s2_gg;
        end
    end

    assign gp = r_s3_gp;
    assign gg = r_s3_gg;
`endif

    assign s    = r_s3_sum;
    assign cout = r_s3_flags.cout;
    assign ovf  = r_s3_flags.ovf;
    assign zero = r_s3_flags.zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: self-checking bench for cla_pipe_adder. Three instances
// (32/4, 16/8, 4/4) share the handshake inputs and run in lockstep; a
// scoreboard built from plain arithmetic checks every delivered result.
// Build with CLA_PG_OUT_EN defined to also check gp/gg.
module tb_cla_pipe_adder;
    import cla_pkg::*;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [7:0]  gp;
        logic [7:0]  gg;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c0;
        logic        sub;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    localparam int WID [3] = '{32, 16, 4};
    localparam int GRP [3] = '{4, 8, 4};

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c0;
    logic        sub;

    logic        ir32, ov32, co32, of32, z32;
    logic [31:0] s32;
    logic        ir16, ov16, co16, of16, z16;
    logic [15:0] s16;
    logic        ir4, ov4, co4, of4, z4;
    logic [3:0]  s4;
`ifdef CLA_PG_OUT_EN
    logic [7:0]  gp32, gg32;
    logic [1:0]  gp16, gg16;
    logic [0:0]  gp4, gg4;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q [3][$];
    logic stall_prev = 1'b0;
    logic [31:0] s_prev = '0;

    cla_pipe_adder #(.WIDTH(32), .GROUP(4)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir32),
        .a(a), .b(b), .c0(c0), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready),
`ifdef CLA_PG_OUT_EN
        .gp(gp32), .gg(gg32),
`endif
        .s(s32), .cout(co32), .ovf(of32), .zero(z32)
    );

    cla_pipe_adder #(.WIDTH(16), .GROUP(8)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir16),
        .a(a[15:0]), .b(b[15:0]), .c0(c0), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready),
`ifdef CLA_PG_OUT_EN
        .gp(gp16), .gg(gg16),
`endif
        .s(s16), .cout(co16), .ovf(of16), .zero(z16)
    );

    cla_pipe_adder #(.WIDTH(4), .GROUP(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
        .a(a[3:0]), .b(b[3:0]), .c0(c0), .sub(sub),
        .out_valid(ov4), .out_ready(out_ready),
`ifdef CLA_PG_OUT_EN
        .gp(gp4), .gg(gg4),
`endif
        .s(s4), .cout(co4), .ovf(of4), .zero(z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: modular arithmetic on wide integers, signed overflow from
    // operand/result signs, group P/G from per-group sub-sums.
    function automatic exp_t model(input int w, input int grp, input logic [31:0] av_in,
                                   input logic [31:0] bv_in, input logic c0v, input logic subv);
        exp_t e;
        longint unsigned mask, av, bv, cv, full, gm, ga, gb;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, av_in} & mask;
        bv   = subv ? (~{32'd0, bv_in}) & mask : {32'd0, bv_in} & mask;
        cv   = subv ? 64'd1 : 64'(c0v);
        full = av + bv + cv;
        e.s    = 32'(full & mask);
        e.cout = ((full >> w) & 64'd1) != 0;
        e.zero = (full & mask) == 0;
        e.ovf  = (((av >> (w-1)) & 64'd1) == ((bv >> (w-1)) & 64'd1)) &&
                 (((full >> (w-1)) & 64'd1) != ((av >> (w-1)) & 64'd1));
        e.gp = '0;
        e.gg = '0;
        gm   = (64'd1 << grp) - 64'd1;
        for (int k = 0; k < w / grp; k++) begin
            ga = (av >> (k*grp)) & gm;
            gb = (bv >> (k*grp)) & gm;
            e.gp[k] = ((ga ^ gb) == gm);
            e.gg[k] = ((ga + gb) >> grp) != 0;
        end
        return e;
    endfunction

    task automatic score(input int i, input string tag, input logic ov, input logic [31:0] sv,
                         input logic co, input logic ofl, input logic zv,
                         input logic [7:0] gpv, input logic [7:0] ggv);
        exp_t e;
        if (ov && out_ready) begin
            checks++;
            if (q[i].size() == 0) begin
                errors++;
                $display("FAIL %s_unexpected: got a valid result, expected none in flight", tag);
            end else begin
                e = q[i].pop_front();
                chk({tag, "_s"},    sv,       e.s);
                chk({tag, "_cout"}, 32'(co),  32'(e.cout));
                chk({tag, "_ovf"},  32'(ofl), 32'(e.ovf));
                chk({tag, "_zero"}, 32'(zv),  32'(e.zero));
`ifdef CLA_PG_OUT_EN
                chk({tag, "_gp"},   32'(gpv), 32'(e.gp));
                chk({tag, "_gg"},   32'(ggv), 32'(e.gg));
`endif
            end
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle when everything is settled
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(ov32), 32'd1);
                chk("hold_s", s32, s_prev);
            end
            chk("in_ready_rule32", 32'(ir32), 32'(!(ov32 && !out_ready)));
            chk("in_ready_rule16", 32'(ir16), 32'(!(ov16 && !out_ready)));
            chk("in_ready_rule4",  32'(ir4),  32'(!(ov4 && !out_ready)));
`ifdef CLA_PG_OUT_EN
            score(0, "w32", ov32, s32, co32, of32, z32, gp32, gg32);
            score(1, "w16", ov16, 32'(s16), co16, of16, z16, 8'(gp16), 8'(gg16));
            score(2, "w4",  ov4,  32'(s4),  co4,  of4,  z4,  8'(gp4),  8'(gg4));
`else
            score(0, "w32", ov32, s32, co32, of32, z32, 8'd0, 8'd0);
            score(1, "w16", ov16, 32'(s16), co16, of16, z16, 8'd0, 8'd0);
            score(2, "w4",  ov4,  32'(s4),  co4,  of4,  z4,  8'd0, 8'd0);
`endif
            if (in_valid && ir32) begin
                for (int i = 0; i < 3; i++) q[i].push_back(model(WID[i], GRP[i], a, b, c0, sub));
            end
            checks++;
            if (q[0].size() > LATENCY) begin
                errors++;
                $display("FAIL in_flight: got %0d held, expected at most %0d", q[0].size(), LATENCY);
            end
            stall_prev = ov32 && !out_ready;
            s_prev     = s32;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
        a = av; b = bv; c0 = cv; sub = sv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    vec_t vecs [10];
    int   idx, nrecv, stall_left, n_acc;
    logic started;

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h00000005, 32'h00000009, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h00000003, 32'h00000004, 1'b1, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c0 = 1'b0; sub = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready", 32'(ir32), 32'd1);
        chk("rst_out_valid", 32'(ov32), 32'd0);
        chk("rst_s", s32, 32'd0);
        chk("rst_flags", 32'({co32, of32, z32}), 32'd0);
`ifdef CLA_PG_OUT_EN
        chk("rst_gp", 32'(gp32), 32'd0);
        chk("rst_gg", 32'(gg32), 32'd0);
`endif
        reset = 1'b0;
        chk("post_rst_in_ready", 32'(ir32), 32'd1);

        // 4-bit basic add with exact 3-cycle latency
        send(32'd7, 32'd7, 1'b1, 1'b0);
        chk("lat_c1_valid", 32'(ov4), 32'd0);
        tick();
        chk("lat_c2_valid", 32'(ov4), 32'd0);
        tick();
        chk("lat_c3_valid", 32'(ov4), 32'd1);
        chk("w4_basic_s", 32'(s4), 32'd15);
        chk("w4_basic_cout", 32'(co4), 32'd0);
        chk("w4_basic_ovf", 32'(of4), 32'd1);
        chk("w4_basic_zero", 32'(z4), 32'd0);
        $display("txn w4 a=7 b=7 c0=1 -> s=%0d cout=%0b ovf=%0b zero=%0b", s4, co4, of4, z4);

        // Directed table on the 32-bit instance
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sub);
            tick();
            tick();
            chk("vec_valid", 32'(ov32), 32'd1);
            chk("vec_s", s32, vecs[i].s);
            chk("vec_cout", 32'(co32), 32'(vecs[i].cout));
            chk("vec_ovf", 32'(of32), 32'(vecs[i].ovf));
            chk("vec_zero", 32'(z32), 32'(vecs[i].zero));
            $display("txn vec%0d a=%08h b=%08h c0=%0b sub=%0b -> s=%08h cout=%0b ovf=%0b zero=%0b",
                     i, vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sub, s32, co32, of32, z32);
        end
        repeat (2) tick();

        // Five back-to-back transactions with a 4-cycle consumer stall
        idx = 0; nrecv = 0; stall_left = 0; started = 1'b0;
        for (int cyc = 0; cyc < 40 && nrecv < 5; cyc++) begin
            if (!started && ov32) begin
                started    = 1'b1;
                stall_left = 4;
            end
            out_ready = (stall_left == 0);
            in_valid  = (idx < 5);
            a = 32'(idx + 1) << 8; b = 32'(idx); c0 = 1'b0; sub = 1'b0;
            #1;
            if (stall_left > 0) begin
                chk("stall_in_ready", 32'(ir32), 32'd0);
                stall_left--;
            end
            if (in_valid && ir32) idx++;
            if (ov32 && out_ready) nrecv++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("b2b_sent", 32'(idx), 32'd5);
        chk("b2b_recv", 32'(nrecv), 32'd5);
        $display("txn b2b sent=%0d received=%0d", idx, nrecv);
        repeat (3) tick();

        // Reset with two transactions in flight
        a = 32'h11; b = 32'h22; in_valid = 1'b1;
        tick();
        a = 32'h33; b = 32'h44;
        tick();
        in_valid = 1'b0; reset = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(ir32), 32'd1);
        tick();
        reset = 1'b0;
        chk("rst_mid_valid", 32'(ov32), 32'd0);
        chk("rst_mid_s", s32, 32'd0);
        chk("rst_mid_zero", 32'(z32), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("no_stale", 32'(ov32), 32'd0);
            tick();
        end

        // Reset overrides a stalled result
        out_ready = 1'b0;
        send(32'd5, 32'd6, 1'b0, 1'b0);
        for (int k = 0; k < 5 && !ov32; k++) tick();
        chk("stall_seen", 32'(ov32), 32'd1);
        chk("stall_blocks", 32'(ir32), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_over_stall_ready", 32'(ir32), 32'd1);
        tick();
        reset = 1'b0;
        chk("rst_over_stall_valid", 32'(ov32), 32'd0);
        chk("first_after_rst_ready", 32'(ir32), 32'd1);
        out_ready = 1'b1;
        tick();

        // Random regression against the reference model
        n_acc = 0;
        for (int cyc = 0; cyc < 40000 && n_acc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = $urandom;
            b   = $urandom;
            c0  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = 32'hFFFFFFFF;
                1: b = a;
                2: a = 32'h80000000;
                3: b = 32'h7FFFFFFF;
                default: ;
            endcase
            #1;
            if (in_valid && ir32) n_acc++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("rand_accepted", 32'(n_acc), 32'd10000);
        for (int k = 0; k < 10 && q[0].size() != 0; k++) tick();
        chk("drain_empty32", 32'(q[0].size()), 32'd0);
        chk("drain_empty16", 32'(q[1].size()), 32'd0);
        chk("drain_empty4",  32'(q[2].size()), 32'd0);
        $display("txn random accepted=%0d", n_acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
